// File: rtl/score_tracker_pkg.sv
// score_tracker shared definitions.
// Channel FSM encoding, score mode constants, winner width helper.
package score_tracker_pkg;

  typedef enum logic [1:0] {
    CH_IDLE  = 2'd0,
    CH_ARMED = 2'd1,
    CH_HELD  = 2'd2
  } ch_state_e;

  localparam int MODE_SAT  = 0;
  localparam int MODE_WRAP = 1;

  function automatic int win_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/score_channel.sv
// score_channel: one player's arm/hold event FSM and score register.
// Exposes the next score so the top can detect a win on the same edge.
module score_channel
  import score_tracker_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int WRAP  = MODE_SAT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             hit,
  input  logic             freeze,
  output logic [WIDTH-1:0] score,
  output logic             point_pulse,
  output logic [WIDTH-1:0] score_nxt,
  output logic             inc
);

  ch_state_e state;
  ch_state_e state_nxt;

  always_comb begin
    state_nxt = state;
    inc       = 1'b0;
    unique case (state)
      CH_IDLE: begin
        if (hit && !freeze)
          state_nxt = CH_ARMED;
      end
      CH_ARMED: begin
        inc       = !freeze;
        state_nxt = CH_HELD;
      end
      CH_HELD: begin
        if (!hit)
          state_nxt = CH_IDLE;
      end
      default: state_nxt = CH_IDLE;
    endcase
  end

  // At the top value the score either rolls to 0 or sticks.
  always_comb begin
    score_nxt = score;
    if (inc) begin
      if (score == '1)
        score_nxt = (WRAP == MODE_WRAP) ? '0 : score;
      else
        score_nxt = score + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state       <= CH_IDLE;
      score       <= '0;
      point_pulse <= 1'b0;
    end else begin
      state       <= state_nxt;
      score       <= score_nxt;
      point_pulse <= inc;
    end
  end

endmodule

// File: rtl/score_tracker.sv
// score_tracker: per-player scoring, win detection and high score.
// Lowest index wins ties; high_score survives round clears.
module score_tracker
  import score_tracker_pkg::*;
#(
  parameter int N_PLAYERS = 2,
  parameter int WIDTH     = 5,
  parameter int WIN_SCORE = 21,
  parameter int WRAP      = MODE_SAT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic [N_PLAYERS-1:0]         hit,
  output logic [N_PLAYERS*WIDTH-1:0]   score,
  output logic [N_PLAYERS-1:0]         point_pulse,
  output logic                         game_over,
  output logic [win_w(N_PLAYERS)-1:0]  winner,
  output logic [WIDTH-1:0]             high_score
);

  localparam int WW = win_w(N_PLAYERS);

  // Targets that no score can reach simply never win.
  localparam bit WIN_EN =
    (WIN_SCORE > 0) && (WIN_SCORE < 2 ** WIDTH);
  localparam logic [WIDTH-1:0] WIN_VAL = WIDTH'(WIN_SCORE);

  logic [WIDTH-1:0]     ch_score [N_PLAYERS];
  logic [WIDTH-1:0]     ch_nxt   [N_PLAYERS];
  logic [N_PLAYERS-1:0] ch_inc;

  logic                 win_hit;
  logic [WW-1:0]        win_idx;
  logic [WIDTH-1:0]     score_max;

  for (genvar i = 0; i < N_PLAYERS; i++) begin : g_ch
    score_channel #(
      .WIDTH (WIDTH),
      .WRAP  (WRAP)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .clear       (clear),
      .hit         (hit[i]),
      .freeze      (game_over),
      .score       (ch_score[i]),
      .point_pulse (point_pulse[i]),
      .score_nxt   (ch_nxt[i]),
      .inc         (ch_inc[i])
    );

    assign score[i*WIDTH +: WIDTH] = ch_score[i];
  end

  // Scan high to low so the lowest matching index is kept.
  always_comb begin
    win_hit = 1'b0;
    win_idx = '0;
    for (int i = N_PLAYERS - 1; i >= 0; i--) begin
      if (WIN_EN && ch_inc[i] && (ch_nxt[i] == WIN_VAL)) begin
        win_hit = 1'b1;
        win_idx = WW'(i);
      end
    end
  end

  always_comb begin
    score_max = high_score;
    for (int i = 0; i < N_PLAYERS; i++) begin
      if (ch_score[i] > score_max)
        score_max = ch_score[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      game_over <= 1'b0;
      winner    <= '0;
    end else if (!game_over && win_hit) begin
      game_over <= 1'b1;
      winner    <= win_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      high_score <= '0;
    else
      high_score <= score_max;
  end

endmodule

// File: tb/tb_score_tracker.sv
// Randomized scoreboard bench for score_tracker.
// Three configurations share stimulus: win, wrap, and saturate.
module tb_score_tracker;

  localparam int NCYC = 4000;
  localparam int NP  [3] = '{2, 3, 1};
  localparam int WD  [3] = '{5, 3, 2};
  localparam int WIN [3] = '{21, 0, 0};
  localparam int WRP [3] = '{0, 1, 0};

  typedef struct packed {
    logic [2:0][14:0] sc;
    logic [2:0][2:0]  pp;
    logic [2:0]       go;
    logic [2:0][1:0]  wn;
    logic [2:0][4:0]  hs;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic [2:0] hit;

  logic [9:0] s0;
  logic [1:0] p0;
  logic       g0;
  logic [0:0] w0;
  logic [4:0] h0;

  logic [8:0] s1;
  logic [2:0] p1;
  logic       g1;
  logic [1:0] w1;
  logic [2:0] h1;

  logic [1:0] s2;
  logic [0:0] p2;
  logic       g2;
  logic [0:0] w2;
  logic [1:0] h2;

  int tests = 0;
  int fails = 0;
  obs_t expq [$];

  int m_sc   [3][3];
  bit m_pend [3][3];
  bit m_eng  [3][3];
  bit m_pp   [3][3];
  bit m_go   [3];
  int m_win  [3];
  int m_hs   [3];

  always #5 clk = ~clk;

  score_tracker #(
    .N_PLAYERS (2), .WIDTH (5), .WIN_SCORE (21), .WRAP (0)
  ) u0 (
    .clk (clk), .reset (reset), .clear (clear), .hit (hit[1:0]),
    .score (s0), .point_pulse (p0), .game_over (g0),
    .winner (w0), .high_score (h0)
  );

  score_tracker #(
    .N_PLAYERS (3), .WIDTH (3), .WIN_SCORE (0), .WRAP (1)
  ) u1 (
    .clk (clk), .reset (reset), .clear (clear), .hit (hit),
    .score (s1), .point_pulse (p1), .game_over (g1),
    .winner (w1), .high_score (h1)
  );

  score_tracker #(
    .N_PLAYERS (1), .WIDTH (2), .WIN_SCORE (0), .WRAP (0)
  ) u2 (
    .clk (clk), .reset (reset), .clear (clear), .hit (hit[0:0]),
    .score (s2), .point_pulse (p2), .game_over (g2),
    .winner (w2), .high_score (h2)
  );

  // Reference: an event is accepted on a rising, un-busy hit, pays
  // one point on the next edge, and the channel stays busy until
  // hit is seen low after the payout.
  task automatic model_step(input bit rst, input bit clr,
                            input logic [2:0] h);
    for (int d = 0; d < 3; d++) begin
      int mx;
      int wn;
      int top;
      mx  = m_hs[d];
      wn  = -1;
      top = (1 << WD[d]) - 1;
      for (int c = 0; c < NP[d]; c++)
        if (m_sc[d][c] > mx) mx = m_sc[d][c];
      if (rst || clr) begin
        for (int c = 0; c < 3; c++) begin
          m_sc[d][c]   = 0;
          m_pend[d][c] = 0;
          m_eng[d][c]  = 0;
          m_pp[d][c]   = 0;
        end
        m_go[d]  = 0;
        m_win[d] = 0;
        m_hs[d]  = rst ? 0 : mx;
      end else begin
        for (int c = 0; c < NP[d]; c++) begin
          bit award;
          award = m_pend[d][c] && !m_go[d];
          m_pp[d][c] = award;
          if (award) begin
            if (WRP[d] != 0)
              m_sc[d][c] = (m_sc[d][c] + 1) % (top + 1);
            else if (m_sc[d][c] < top)
              m_sc[d][c] = m_sc[d][c] + 1;
            if (WIN[d] != 0 && m_sc[d][c] == WIN[d] && wn < 0)
              wn = c;
          end
          if (m_pend[d][c])
            m_pend[d][c] = 0;
          else if (!m_eng[d][c] && h[c] && !m_go[d]) begin
            m_pend[d][c] = 1;
            m_eng[d][c]  = 1;
          end else if (m_eng[d][c] && !h[c])
            m_eng[d][c] = 0;
        end
        if (wn >= 0) begin
          m_go[d]  = 1;
          m_win[d] = wn;
        end
        m_hs[d] = mx;
      end
    end
  endtask

  function automatic obs_t model_obs();
    obs_t e;
    e = '0;
    for (int d = 0; d < 3; d++) begin
      for (int c = 0; c < NP[d]; c++) begin
        e.sc[d] = e.sc[d] | 15'(m_sc[d][c] << (c * WD[d]));
        e.pp[d][c] = m_pp[d][c];
      end
      e.go[d] = m_go[d];
      e.wn[d] = 2'(m_win[d]);
      e.hs[d] = 5'(m_hs[d]);
    end
    return e;
  endfunction

  function automatic obs_t dut_obs();
    obs_t a;
    a = '0;
    a.sc[0] = 15'(s0); a.pp[0] = 3'(p0); a.go[0] = g0;
    a.wn[0] = 2'(w0); a.hs[0] = 5'(h0);
    a.sc[1] = 15'(s1); a.pp[1] = 3'(p1); a.go[1] = g1;
    a.wn[1] = 2'(w1); a.hs[1] = 5'(h1);
    a.sc[2] = 15'(s2); a.pp[2] = 3'(p2); a.go[2] = g2;
    a.wn[2] = 2'(w2); a.hs[2] = 5'(h2);
    return a;
  endfunction

  task automatic check(input string nm, input int d,
                       input logic [14:0] got, input logic [14:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL u%0d %s at %0t: got %0h want %0h",
               d, nm, $time, got, want);
    end
  endtask

  // Monitor: every edge presents a new registered output set.
  initial begin
    obs_t e;
    obs_t a;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL scoreboard at %0t: got empty queue want entry",
                 $time);
      end else begin
        e = expq.pop_front();
        a = dut_obs();
        for (int d = 0; d < 3; d++) begin
          check("score", d, a.sc[d], e.sc[d]);
          check("point_pulse", d, 15'(a.pp[d]), 15'(e.pp[d]));
          check("game_over", d, 15'(a.go[d]), 15'(e.go[d]));
          check("winner", d, 15'(a.wn[d]), 15'(e.wn[d]));
          check("high_score", d, 15'(a.hs[d]), 15'(e.hs[d]));
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    clear = 1'b0;
    hit   = '0;
    model_step(reset, clear, hit);
    expq.push_back(model_obs());
    for (int k = 0; k < NCYC; k++) begin
      @(posedge clk);
      #2;
      reset = 1'b0;
      clear = 1'b0;
      if (k < 3) begin
        reset = 1'b1;
        hit   = '0;
      end else if (k < 23) begin
        hit = (k < 13) ? 3'b111 : 3'b000;
      end else if (k < 43) begin
        hit = (k % 2 == 1) ? 3'b111 : 3'b000;
      end else begin
        if ($urandom_range(0, 1) == 1)
          hit = {3{1'($urandom_range(0, 1))}};
        else
          hit = 3'($urandom);
        reset = ($urandom_range(0, 399) == 0);
        clear = ($urandom_range(0, 199) == 0);
      end
      model_step(reset, clear, hit);
      expq.push_back(model_obs());
    end
    @(posedge clk);
    #3;
    tests++;
    if (expq.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d left want 0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
